// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int         BYTE_W  = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above ptr,
// wrapping around to bit 0.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [N_REQ-1:0] rotated;
    int               offset;
    int               sum;

    // Rotate so that bit 0 is the requester at ptr, find the lowest set bit,
    // then map the offset back to an absolute index.
    always_comb begin
        rotated = N_REQ'({req, req} >> ptr);
        any     = 1'b0;
        offset  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any    = 1'b1;
                offset = i;
            end
        end
        sum = int'(ptr) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        gnt_id = ID_W'(sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin scheduler in front of the Uart transmit enqueue port.
// Define UART_TX_ARB_HDR_EN to prefix every packet with a {4'hA, id} header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_bits,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      uart_enq_valid,
    output logic [BYTE_W-1:0]         uart_enq_bits,
    input  logic                      uart_enq_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_next;
    logic [ID_W-1:0]   grant_next;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_bits;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign owner_bits  = req_bits[grant_id*BYTE_W +: BYTE_W];
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            grant_id <= grant_next;
        end
    end

    // Outputs decode from state alone plus the owner's live inputs, so an
    // asynchronous reset drops valid/ready without waiting for a clock.
    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        grant_next     = grant_id;
        uart_enq_valid = 1'b0;
        uart_enq_bits  = '0;
        req_ready      = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_id;
`ifdef UART_TX_ARB_HDR_EN
                    state_next = HDR;
`else
                    state_next = DATA;
`endif
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            HDR: begin
                uart_enq_valid = 1'b1;
                uart_enq_bits  = {HDR_TAG, 4'(grant_id)};
                if (uart_enq_ready) begin
                    state_next = DATA;
                end
            end
`endif
            DATA: begin
                uart_enq_valid      = owner_valid;
                uart_enq_bits       = owner_bits;
                req_ready[grant_id] = uart_enq_ready;
                if (owner_valid && uart_enq_ready && owner_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit enqueue channel of the `Uart` block among `N_REQ` requesters. Arbitration is round-robin and packet-locked: a requester keeps the channel until it delivers a byte marked `last`. The block sits between client logic (command engines, debug/log sources) and `Uart.io_ctl_enq_*`. It is purely a scheduler and adds no buffering in the data path.

## Interface
- `N_REQ`, default 4: number of requesters, 1..16.
- `ID_W`, default 2: grant index width, equal to max(1, clog2(N_REQ)).
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_bits`  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  N_REQ  marks the final byte of the requester's packet.
- `req_ready`  out  N_REQ  per-requester byte accepted.
- `uart_enq_valid`  out  1  drives `Uart.io_ctl_enq_valid`.
- `uart_enq_bits`  out  8  drives `Uart.io_ctl_enq_bits`.
- `uart_enq_ready`  in  1  from `Uart.io_ctl_enq_ready`.
- `grant_id`  out  ID_W  index of the current or most recent owner.
- `busy`  out  1  high while a packet owns the channel.

## Operation
- FSM states: IDLE, HDR, DATA. HDR exists only when `UART_TX_ARB_HDR_EN` is defined.
- **IDLE**
  - All outputs are inactive.
  - If any `req_valid` is high, the winner is the first requester found searching from `rr_ptr` upward with wrap-around.
  - On that edge, `grant_id` takes the winner and the FSM moves to HDR (if built in) or DATA.
- **HDR**
  - `uart_enq_valid=1` and `uart_enq_bits={4'hA, grant_id zero-extended to 4 bits}`.
  - On `uart_enq_ready`, go to DATA.
- **DATA** (combinational pass-through of the owner g)
  - `uart_enq_valid = req_valid[g]`, `uart_enq_bits = req_bits[g]`, `req_ready[g] = uart_enq_ready`.
  - All other `req_ready` bits are 0.
  - A handshake with `req_last[g]=1` returns the FSM to IDLE and sets `rr_ptr = g+1`, wrapping from N_REQ-1 to 0.
- `busy` = (state != IDLE).
- **Boundary conditions**
  - Owner drops `req_valid` mid-packet: the grant is held indefinitely and no other requester is served.
  - Single-byte packet (`last` on the first byte): legal.
  - `req_last` without `req_valid`: ignored.
  - Non-owner requests during DATA: ignored. They compete at the next IDLE cycle.
  - `N_REQ=1`: `rr_ptr` and `grant_id` stay 0.
  - Reset asserted mid-packet: the FSM goes to IDLE immediately. `uart_enq_valid` and all `req_ready` fall asynchronously. The partial packet is abandoned, and the requester must restart it.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `grant_id`=0, `busy`=0
  - `uart_enq_valid`=0, `uart_enq_bits`=0, `req_ready`=0
- Arbitration costs exactly one idle cycle per packet: the first byte is presented on the cycle after the request is seen in IDLE. HDR adds one further cycle minimum.
- Within DATA, throughput is one byte per cycle while `uart_enq_ready` stays high. There is no added latency.
- `uart_enq_valid`, once asserted in HDR, holds with stable bits until ready. In DATA this stability follows the owner's own obligation.

## Configuration
- Macro: `UART_TX_ARB_HDR_EN`.
- **Defined:** each packet is preceded by one header byte `{4'hA, id}`, and the HDR state is present.
- **Undefined:** HDR is removed, IDLE goes directly to DATA, and the byte stream is exactly the requesters' bytes.

## Structure
- Package `uart_arb_pkg`:
  - FSM state enum: IDLE, HDR, DATA
  - `HDR_TAG = 4'hA`
  - `BYTE_W = 8`
- Sub-module `uart_rr_pick`: combinational rotate-priority picker. Inputs are `req` and `ptr`; outputs are `gnt_id` and `any`. It holds the search logic so it can be unit-tested.

## Test plan
- **Single requester, no HDR:** req 0 sends 0xFE, 0x01 (last) with ready=1.
  - UART sees 0xFE then 0x01 on consecutive cycles, one cycle after the request.
  - `busy` is high 2 cycles; `rr_ptr` becomes 1.
- **Fairness:** all 4 requesters hold valid with one-byte packets.
  - Grants go 0, 1, 2, 3, 0, each separated by one IDLE cycle.
- **Lock:** req 2 owns the channel, drops valid for 5 cycles mid-packet while req 1 is valid.
  - No byte from req 1 appears until req 2's last byte is accepted.
- **Backpressure:** `uart_enq_ready` held low 10 cycles during DATA.
  - `req_ready[g]=0` throughout; no byte is lost or duplicated.
- **HDR build:** requester 3 sends 0x55 (last).
  - UART sees 0xA3 then 0x55.
- **Async reset mid-packet:** assert reset between bytes.
  - `uart_enq_valid` and `req_ready` fall without waiting for a clock edge; `grant_id`=0.
  - After release, a new request is served starting from requester 0.
